// File: rtl/ssio_sdr_in_deskew.sv
// rtl/ssio_sdr_in_deskew.sv - multi-lane SDR input capture with per-lane deskew and frame tracking
// Optional frame statistics are built when SSIO_SDR_IN_DESKEW_STATS_EN is defined.
module ssio_sdr_in_deskew #(
  parameter int WIDTH    = 4,
  parameter int MAX_SKEW = 3,
  parameter int SW       = $clog2(MAX_SKEW + 1)
) (
  input  logic                    input_clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        input_d,
  input  logic                    input_ctl,
  input  logic [(WIDTH+1)*SW-1:0] skew_sel,
  input  logic                    skew_load,
  output logic                    skew_busy,
  output logic                    output_clk,
  output logic [WIDTH-1:0]        output_q,
  output logic                    output_ctl,
  output logic [15:0]             frame_len,
  output logic                    frame_done
);

  localparam int L = WIDTH + 1;
  localparam logic [SW-1:0] FLUSH_LAST = SW'(MAX_SKEW - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  logic [L-1:0]               cap_q, cap_d;
  logic [MAX_SKEW-1:0][L-1:0] dly_q, dly_d;
  logic [L-1:0]               out_q, out_d;
  logic [L*SW-1:0]            act_sel_q, act_sel_d;
  logic [L*SW-1:0]            pend_sel_q, pend_sel_d;
  logic                       busy_q, busy_d;
  state_t                     state_q, state_d;
  logic [SW-1:0]              flush_cnt_q, flush_cnt_d;
  logic                       ctl_aligned;

  assign output_clk  = input_clk;
  assign output_q    = out_q[WIDTH-1:0];
  assign output_ctl  = out_q[WIDTH];
  assign skew_busy   = busy_q;
  assign ctl_aligned = out_q[WIDTH];

  // Capture stage feeding free-running per-lane delay lines
  always_comb begin
    cap_d    = {input_ctl, input_d};
    dly_d    = dly_q;
    dly_d[0] = cap_q;
    for (int k = 1; k < MAX_SKEW; k++) dly_d[k] = dly_q[k-1];
  end

  // Per-lane tap select, clamped to the deepest stage; select 0 bypasses the line
  always_comb begin
    logic [SW-1:0] sel;
    sel   = '0;
    out_d = '0;
    for (int l = 0; l < L; l++) begin
      sel = act_sel_q[l*SW +: SW];
      if (int'(sel) > MAX_SKEW) sel = SW'(MAX_SKEW);
      out_d[l] = cap_q[l];
      for (int k = 1; k <= MAX_SKEW; k++) begin
        if (sel == SW'(k)) out_d[l] = dly_q[k-1][l];
      end
    end
  end

  // Frame FSM: selects change only while the aligned link is idle
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    act_sel_d   = act_sel_q;
    pend_sel_d  = pend_sel_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (ctl_aligned) begin
          // a load on the entry edge already belongs to the frame
          state_d = S_ACTIVE;
          if (skew_load) begin
            pend_sel_d = skew_sel;
            busy_d     = 1'b1;
          end
        end else if (skew_load) begin
          act_sel_d = skew_sel;
        end
      end
      S_ACTIVE: begin
        if (skew_load) begin
          pend_sel_d = skew_sel;
          busy_d     = 1'b1;
        end
        if (!ctl_aligned) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end
      end
      S_FLUSH: begin
        if (skew_load) begin
          pend_sel_d = skew_sel;
          busy_d     = 1'b1;
        end
        if (ctl_aligned) begin
          state_d = S_ACTIVE;
        end else if (flush_cnt_q == '0) begin
          state_d = S_IDLE;
          if (skew_load) act_sel_d = skew_sel;
          else if (busy_q) act_sel_d = pend_sel_q;
          busy_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and control registers; reset drops any pending load
  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= '0;
      dly_q       <= '0;
      out_q       <= '0;
      act_sel_q   <= '0;
      pend_sel_q  <= '0;
      busy_q      <= 1'b0;
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
    end else begin
      cap_q       <= cap_d;
      dly_q       <= dly_d;
      out_q       <= out_d;
      act_sel_q   <= act_sel_d;
      pend_sel_q  <= pend_sel_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef SSIO_SDR_IN_DESKEW_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic        done_q, done_d;

  // Saturating frame-length counter; the cycle that triggers ACTIVE entry is the first counted
  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    done_d = 1'b0;
    if (state_q == S_ACTIVE) begin
      if (ctl_aligned) begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else begin
        len_d  = cnt_q;
        done_d = 1'b1;
      end
    end else if (ctl_aligned) begin
      cnt_d = 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  assign frame_len  = len_q;
  assign frame_done = done_q;
`else
  assign frame_len  = 16'd0;
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_ssio_sdr_in_deskew.sv
// tb/tb_ssio_sdr_in_deskew.sv - scoreboard bench for ssio_sdr_in_deskew
module tb_ssio_sdr_in_deskew;

  localparam int W  = 4;
  localparam int MS = 3;
  localparam int SW = $clog2(MS + 1);
  localparam int L  = W + 1;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    input_d;
  logic            input_ctl;
  logic [L*SW-1:0] skew_sel;
  logic            skew_load;
  logic            skew_busy;
  logic            output_clk;
  logic [W-1:0]    output_q;
  logic            output_ctl;
  logic [15:0]     frame_len;
  logic            frame_done;

  ssio_sdr_in_deskew #(.WIDTH(W), .MAX_SKEW(MS)) dut (
    .input_clk (clk),
    .rst_n     (rst_n),
    .input_d   (input_d),
    .input_ctl (input_ctl),
    .skew_sel  (skew_sel),
    .skew_load (skew_load),
    .skew_busy (skew_busy),
    .output_clk(output_clk),
    .output_q  (output_q),
    .output_ctl(output_ctl),
    .frame_len (frame_len),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] expq [$];
  int           flq  [$];
  int           slq  [$];
  logic [L-1:0] hist [$];
  int           bd   [L];
  int           run  = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [L*SW-1:0] mk_sel(input int s0, s1, s2, s3, sc);
    int s [L];
    logic [L*SW-1:0] v;
    s = '{s0, s1, s2, s3, sc};
    v = '0;
    for (int l = 0; l < L; l++) v[l*SW +: SW] = SW'(s[l]);
    return v;
  endfunction

  // Pins see the logical word through a per-lane board delay; frame words become expectations.
  task automatic drive_word(input logic [L-1:0] w);
    logic [L-1:0] pins;
    logic [L-1:0] tmp;
    hist.push_front(w);
    void'(hist.pop_back());
    pins = '0;
    for (int l = 0; l < L; l++) begin
      tmp     = hist[bd[l]];
      pins[l] = tmp[l];
    end
    input_d   = pins[W-1:0];
    input_ctl = pins[W];
    if (w[W]) expq.push_back(w[W-1:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_word('0);
    end
  endtask

  task automatic send_frame(input int len, input bit walk);
    logic [W-1:0] d;
    flq.push_back(len);
    slq.push_back(len > 65535 ? 65535 : len);
    for (int i = 0; i < len; i++) begin
      d = walk ? W'(1 << (i % W)) : W'($urandom);
      @(negedge clk);
      drive_word({1'b1, d});
    end
  endtask

  task automatic rand_frames(input int n);
    for (int f = 0; f < n; f++) begin
      send_frame($urandom_range(1, 12), 1'b0);
      idle($urandom_range(1, 4));
    end
  endtask

  task automatic load_idle(input logic [L*SW-1:0] v, input int b0, b1, b2, b3, bc);
    idle(12);
    @(negedge clk);
    skew_sel  = v;
    skew_load = 1'b1;
    drive_word('0);
    @(negedge clk);
    skew_load = 1'b0;
    chk_eq("busy_idle_load", {31'b0, skew_busy}, 32'd0);
    drive_word('0);
    bd = '{b0, b1, b2, b3, bc};
    idle(6);
  endtask

  // Single-cycle pulse on the data lanes with ctl low; returns edges until it shows on output_q
  task automatic measure_latency(input logic [W-1:0] pat, output int lat);
    @(negedge clk);
    drive_word({1'b0, pat});
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive_word('0);
      if (lat < 0 && output_q == pat) lat = k;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_q"},    {28'b0, output_q},   32'd0);
    chk_eq({tag, "_ctl"},  {31'b0, output_ctl}, 32'd0);
    chk_eq({tag, "_busy"}, {31'b0, skew_busy},  32'd0);
    chk_eq({tag, "_len"},  {16'b0, frame_len},  32'd0);
    chk_eq({tag, "_done"}, {31'b0, frame_done}, 32'd0);
  endtask

  // Monitor: output_ctl acts as valid; data and frame lengths come from the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (output_ctl) begin
        if (expq.size() == 0) chk_eq("sb_unexpected_word", {28'b0, output_q}, 32'hFFFF_FFFF);
        else chk_eq("sb_data", {28'b0, output_q}, {28'b0, expq.pop_front()});
        run++;
      end else if (run != 0) begin
        if (flq.size() == 0) chk_eq("sb_unexpected_frame", run, 32'hFFFF_FFFF);
        else chk_eq("ctl_frame_len", run, flq.pop_front());
        run = 0;
      end
`ifdef SSIO_SDR_IN_DESKEW_STATS_EN
      if (frame_done) begin
        if (slq.size() == 0) chk_eq("stats_unexpected_done", {16'b0, frame_len}, 32'hFFFF_FFFF);
        else chk_eq("stats_frame_len", {16'b0, frame_len}, slq.pop_front());
      end
`else
      chk_eq("stats_len_tied", {16'b0, frame_len}, 32'd0);
      chk_eq("stats_done_tied", {31'b0, frame_done}, 32'd0);
`endif
    end
  end

  initial begin
    int  lat;
    int  hi_cnt;
    int  k_f;
    bit  fell;
    bit  busy_done;
    bit  loaded;

    rst_n     = 1'b0;
    skew_load = 1'b0;
    skew_sel  = '0;
    input_d   = '1;
    input_ctl = 1'b1;
    bd        = '{0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) hist.push_back('0);

    // outputs held at zero while in reset even with busy pins
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");

    @(negedge clk);
    drive_word('0);
    @(negedge clk);
    drive_word('0);
    rst_n = 1'b1;
    @(negedge clk);
    drive_word('0);
    check_all_zero("after_reset");
    chk_eq("output_clk_follow", {31'b0, output_clk}, {31'b0, clk});

    // zero selects: two-cycle pin-to-output latency
    measure_latency(4'hA, lat);
    chk_eq("latency_sel0", lat, 32'd2);

    rand_frames(5);
    idle(2);
    send_frame(8, 1'b1);

    // board skew {0,1,2,3}, ctl 1, compensated by selects {3,2,1,0}, ctl 2
    load_idle(mk_sel(3, 2, 1, 0, 2), 0, 1, 2, 3, 1);
    send_frame(8, 1'b1);
    idle(2);
    rand_frames(6);
    idle(12);

    // load during an 8-cycle frame: pending until the flush completes
    flq.push_back(8);
    slq.push_back(8);
    hi_cnt    = 0;
    fell      = 1'b0;
    k_f       = 0;
    busy_done = 1'b0;
    for (int k = 0; k < 60 && !busy_done; k++) begin
      @(negedge clk);
      if (!fell) begin
        if (output_ctl) begin
          hi_cnt++;
          if (hi_cnt == 2) begin
            chk_eq("busy_before_load", {31'b0, skew_busy}, 32'd0);
            skew_sel  = mk_sel(1, 1, 1, 1, 1);
            skew_load = 1'b1;
          end else if (hi_cnt == 3) begin
            skew_load = 1'b0;
            chk_eq("busy_rise", {31'b0, skew_busy}, 32'd1);
          end
        end else if (hi_cnt > 0) begin
          fell = 1'b1;
          k_f  = k;
        end
      end
      if (fell && !skew_busy) begin
        // one edge to see the fall, then MS flush cycles ending on the commit edge
        chk_eq("busy_fall_edges", k - k_f, MS + 1);
        busy_done = 1'b1;
      end
      drive_word(k < 8 ? {1'b1, W'($urandom)} : '0);
    end
    if (!busy_done) chk_eq("busy_fall_timeout", 32'd0, 32'd1);
    skew_load = 1'b0;
    idle(4);
    bd = '{2, 2, 2, 2, 2};
    idle(6);
    rand_frames(5);
    send_frame(8, 1'b1);

    // over-range select on lane 0 clamps to the deepest tap
    load_idle(mk_sel(7, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    measure_latency(4'h1, lat);
    chk_eq("latency_clamped", lat, 2 + MS);
    measure_latency(4'h2, lat);
    chk_eq("latency_lane1_sel0", lat, 32'd2);

    // reset mid-frame with a load pending
    load_idle(mk_sel(2, 2, 2, 2, 2), 1, 1, 1, 1, 1);
    flq.push_back(10);
    slq.push_back(10);
    hi_cnt = 0;
    loaded = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (output_ctl) hi_cnt++;
      if (hi_cnt == 2 && !loaded) begin
        skew_sel  = mk_sel(3, 0, 3, 1, 2);
        skew_load = 1'b1;
        loaded    = 1'b1;
      end else begin
        skew_load = 1'b0;
      end
      drive_word({1'b1, W'($urandom)});
    end
    @(negedge clk);
    skew_load = 1'b0;
    chk_eq("busy_pending_pre_reset", {31'b0, skew_busy}, 32'd1);
    drive_word('0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expq.delete();
    flq.delete();
    slq.delete();
    #1;
    check_all_zero("mid_frame_reset");
    bd = '{0, 0, 0, 0, 0};
    idle(4);
    @(negedge clk);
    rst_n = 1'b1;
    drive_word('0);
    @(negedge clk);
    drive_word('0);
    check_all_zero("post_mid_reset");
    measure_latency(4'hA, lat);
    chk_eq("latency_after_reset", lat, 32'd2);
    rand_frames(3);
    idle(12);
    measure_latency(4'h5, lat);
    chk_eq("pending_discarded", lat, 32'd2);

    // frame statistics across short, medium and saturating frames
    send_frame(1, 1'b0);
    idle(10);
    send_frame(64, 1'b0);
    idle(10);
    send_frame(70000, 1'b0);
    idle(15);

    chk_eq("sb_data_drained", expq.size(), 32'd0);
    chk_eq("sb_frames_drained", flq.size(), 32'd0);
`ifdef SSIO_SDR_IN_DESKEW_STATS_EN
    chk_eq("stats_done_count", slq.size(), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
